// File: rtl/screen_fader_if.sv
// screen_fader_if: pixel, frame and fade-control signals between the display
// pipeline and the screen fader.
//   frame_start  - one-cycle pulse per frame (start of vertical blank)
//   blank        - active-low display enable (0 = blanking interval)
//   pixel_color  - {R, G, B} from the palette stage
//   fade_out_req - one-cycle request to fade to black
//   fade_in_req  - one-cycle request to fade to full brightness
//   red/green/blue - registered, scaled colour for the DAC
//   level        - current brightness, 0..16
//   busy         - high while a fade is in progress
//   fade_done    - one-cycle pulse when a fade completes
// master: drives the pixel/frame/request side; slave: the fader.
interface screen_fader_if;
    logic        frame_start;
    logic        blank;
    logic [23:0] pixel_color;
    logic        fade_out_req;
    logic        fade_in_req;
    logic [7:0]  red;
    logic [7:0]  green;
    logic [7:0]  blue;
    logic [4:0]  level;
    logic        busy;
    logic        fade_done;

    modport master (
        output frame_start, blank, pixel_color, fade_out_req, fade_in_req,
        input  red, green, blue, level, busy, fade_done
    );

    modport slave (
        input  frame_start, blank, pixel_color, fade_out_req, fade_in_req,
        output red, green, blue, level, busy, fade_done
    );
endinterface

// File: rtl/screen_fader.sv
// screen_fader: scales the palette colour by a global brightness level
// (0..16) and runs frame-synchronous fade-to-black / fade-from-black
// transitions. Blanking forces the output to black.
//   Clk   - pixel clock
//   Reset - asynchronous, active-high reset
//   bus   - screen_fader_if slave (pixel in, scaled colour and status out)
// Colour output has one cycle of latency relative to pixel_color/blank.
module screen_fader #(
    parameter int unsigned FRAMES_PER_STEP = 2
) (
    input  logic           Clk,
    input  logic           Reset,
    screen_fader_if.slave  bus
);
    typedef enum logic [1:0] {
        VISIBLE,
        FADE_OUT,
        BLACK,
        FADE_IN
    } state_t;

    localparam logic [7:0] STEP_LAST = 8'(FRAMES_PER_STEP - 1);

    state_t     state, state_next;
    logic [4:0] level_q, level_next;
    logic [7:0] frame_cnt, frame_cnt_next;
    logic       done_q, done_next;
    logic [7:0] red_q, green_q, blue_q;

    // (c * level) >> 4 with a 13-bit product; level 16 is exact passthrough.
    function automatic logic [7:0] scale(input logic [7:0] c, input logic [4:0] l);
        logic [12:0] p;
        p = 13'(c) * 13'(l);
        return 8'(p >> 4);
    endfunction

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= VISIBLE;
            level_q   <= 5'd16;
            frame_cnt <= '0;
            done_q    <= 1'b0;
            red_q     <= '0;
            green_q   <= '0;
            blue_q    <= '0;
        end else begin
            state     <= state_next;
            level_q   <= level_next;
            frame_cnt <= frame_cnt_next;
            done_q    <= done_next;
            // Scaling uses the level held during this cycle; a step taken at
            // this edge only affects the next pixel.
            red_q     <= bus.blank ? scale(bus.pixel_color[23:16], level_q) : '0;
            green_q   <= bus.blank ? scale(bus.pixel_color[15:8],  level_q) : '0;
            blue_q    <= bus.blank ? scale(bus.pixel_color[7:0],   level_q) : '0;
        end
    end

    always_comb begin
        state_next     = state;
        level_next     = level_q;
        frame_cnt_next = frame_cnt;
        done_next      = 1'b0;
        unique case (state)
            VISIBLE: begin
                if (bus.fade_out_req) begin
                    state_next     = FADE_OUT;
                    frame_cnt_next = '0;
                end
            end
            BLACK: begin
                if (bus.fade_in_req) begin
                    state_next     = FADE_IN;
                    frame_cnt_next = '0;
                end
            end
            FADE_OUT: begin
                if (bus.frame_start) begin
                    if (frame_cnt == STEP_LAST) begin
                        frame_cnt_next = '0;
                        level_next     = level_q - 5'd1;
                        if (level_q == 5'd1) begin
                            state_next = BLACK;
                            done_next  = 1'b1;
                        end
                    end else begin
                        frame_cnt_next = frame_cnt + 8'd1;
                    end
                end
            end
            FADE_IN: begin
                if (bus.frame_start) begin
                    if (frame_cnt == STEP_LAST) begin
                        frame_cnt_next = '0;
                        level_next     = level_q + 5'd1;
                        if (level_q == 5'd15) begin
                            state_next = VISIBLE;
                            done_next  = 1'b1;
                        end
                    end else begin
                        frame_cnt_next = frame_cnt + 8'd1;
                    end
                end
            end
            default: ;
        endcase
    end

    assign bus.red       = red_q;
    assign bus.green     = green_q;
    assign bus.blue      = blue_q;
    assign bus.level     = level_q;
    assign bus.busy      = (state == FADE_OUT) || (state == FADE_IN);
    assign bus.fade_done = done_q;
endmodule
